// File: rtl/bitmap_alloc.sv
// Registered occupancy bitmap with set/clear decode, lowest-free-slot allocation,
// population count and full/empty flags. All outputs have one cycle of latency.
module bitmap_alloc #(
    parameter int unsigned INWID  = 6,
    parameter int unsigned OUTWID = 48,
    parameter logic        VALUE  = 1'b1
) (
    input  logic              clk,
    input  logic              rst_,
    input  logic              set_en,
    input  logic [INWID-1:0]  set_idx,
    input  logic              clr_en,
    input  logic [INWID-1:0]  clr_idx,
    input  logic              alloc_req,
    output logic              alloc_ack,
    output logic              alloc_nak,
    output logic [INWID-1:0]  alloc_idx,
    output logic [OUTWID-1:0] map,
    output logic [INWID:0]    cnt,
    output logic              full,
    output logic              empty,
    output logic              err
);

    logic [OUTWID-1:0] occ_q, occ_d;
    logic [OUTWID-1:0] set_hot, clr_hot, avail, grant;
    logic [INWID:0]    cnt_q, cnt_d;
    logic [INWID-1:0]  idx_q, idx_d, cand;
    logic              ack_q, ack_d, nak_q, nak_d, err_q, err_d;
    logic              full_q, full_d, empty_q, empty_d;
    logic              set_ok, clr_ok, pair_ok, clr_eff, alloc_ok;

    // Out-of-range indices decode to an all-zero vector, so they can never be legal.
    always_comb begin
        for (int i = 0; i < OUTWID; i++) begin
            set_hot[i] = set_en && (set_idx == INWID'(i));
            clr_hot[i] = clr_en && (clr_idx == INWID'(i));
        end
    end

    always_comb begin
        set_ok   = |(set_hot & ~occ_q);
        clr_ok   = |(clr_hot & occ_q);
        // Same-index set+clear on an occupied slot is a no-op and not an error.
        pair_ok  = set_en && clr_en && (set_idx == clr_idx) && clr_ok;
        clr_eff  = clr_ok && !pair_ok;
        err_d    = (set_en && !set_ok && !pair_ok) || (clr_en && !clr_ok);

        avail    = ~occ_q & ~set_hot;
        grant    = avail & (~avail + 1'b1);
        cand     = '0;
        for (int i = 0; i < OUTWID; i++) begin
            if (grant[i]) begin
                cand = cand | INWID'(i);
            end
        end
        alloc_ok = alloc_req && (|avail);
        ack_d    = alloc_ok;
        nak_d    = alloc_req && !(|avail);
        idx_d    = alloc_ok ? cand : idx_q;

        occ_d    = (occ_q & ~(clr_eff ? clr_hot : '0))
                 | (set_ok ? set_hot : '0)
                 | (alloc_ok ? grant : '0);
        cnt_d    = cnt_q + (INWID+1)'(set_ok) + (INWID+1)'(alloc_ok) - (INWID+1)'(clr_eff);
        full_d   = (cnt_d == (INWID+1)'(OUTWID));
        empty_d  = (cnt_d == '0);
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            occ_q   <= '0;
            cnt_q   <= '0;
            idx_q   <= '0;
            ack_q   <= 1'b0;
            nak_q   <= 1'b0;
            err_q   <= 1'b0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            occ_q   <= occ_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            ack_q   <= ack_d;
            nak_q   <= nak_d;
            err_q   <= err_d;
            full_q  <= full_d;
            empty_q <= empty_d;
        end
    end

    assign map       = VALUE ? occ_q : ~occ_q;
    assign cnt       = cnt_q;
    assign full      = full_q;
    assign empty     = empty_q;
    assign alloc_ack = ack_q;
    assign alloc_nak = nak_q;
    assign alloc_idx = idx_q;
    assign err       = err_q;

endmodule
